// File: rtl/beta_dmem_if.sv
// Core-to-data-memory bus for the beta core: request strobes, address/data,
// combinational load data and the timer interrupt line.
interface beta_dmem_if;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] memReadData;
    logic        irq;

    modport master (
        output memAddr, memWriteData, MemRead, MemWrite,
        input  memReadData, irq
    );

    modport slave (
        input  memAddr, memWriteData, MemRead, MemWrite,
        output memReadData, irq
    );
endinterface

// File: rtl/beta_dmem_io.sv
// Data-memory responder for the beta core: word RAM plus a memory-mapped
// interval timer that drives irq. Loads are combinational, stores commit on
// the rising clock edge.
// Optional macro BETA_DMEM_PRESCALE_EN adds an 8-bit prescaler (PRE at 0x10).
module beta_dmem_io #(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] IO_PAGE = 16'hFFFF
) (
    input  logic         clk,
    input  logic         reset,
    beta_dmem_if.slave   bus
);
    localparam logic [15:0] OFF_CNT  = 16'h0000;
    localparam logic [15:0] OFF_CMP  = 16'h0004;
    localparam logic [15:0] OFF_CTRL = 16'h0008;
    localparam logic [15:0] OFF_STAT = 16'h000C;
`ifdef BETA_DMEM_PRESCALE_EN
    localparam logic [15:0] OFF_PRE  = 16'h0010;
`endif

    // Address decode: upper half selects I/O page, low bits index RAM words.
    logic              io_sel;
    logic [15:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              io_wr, ram_wr;
    logic              wr_cnt, wr_cmp, wr_ctrl, wr_stat;

    assign io_sel  = (bus.memAddr[31:16] == IO_PAGE);
    assign off     = bus.memAddr[15:0];
    assign idx     = bus.memAddr[ADDR_W+1:2];
    assign io_wr   = bus.MemWrite & io_sel;
    assign ram_wr  = bus.MemWrite & ~io_sel;
    assign wr_cnt  = io_wr && (off == OFF_CNT);
    assign wr_cmp  = io_wr && (off == OFF_CMP);
    assign wr_ctrl = io_wr && (off == OFF_CTRL);
    assign wr_stat = io_wr && (off == OFF_STAT);

    // Word RAM; deliberately has no reset so contents survive a core reset.
    logic [31:0] ram [0:(1<<ADDR_W)-1];

    // RAM store port.
    always_ff @(posedge clk) begin
        if (ram_wr) ram[idx] <= bus.memWriteData;
    end

    // Timer state. ctrl[0]=EN, ctrl[1]=IE, ctrl[2]=RELOAD.
    logic [31:0] cnt, cnt_n;
    logic [31:0] cmp;
    logic [2:0]  ctrl, ctrl_n;
    logic        pend, pend_n;
    logic        tick;

`ifdef BETA_DMEM_PRESCALE_EN
    logic       wr_pre;
    logic [7:0] pre;
    logic [7:0] ps_cnt, ps_n;

    assign wr_pre = io_wr && (off == OFF_PRE);
    // Timer only acts on the cycle the prescaler reaches PRE.
    assign tick   = ctrl[0] && (ps_cnt == pre);

    // Prescale counter: 0..PRE while enabled, held at 0 when idle or on CNT load.
    always_comb begin
        ps_n = ps_cnt;
        if (!ctrl[0] || wr_cnt)  ps_n = '0;
        else if (ps_cnt == pre)  ps_n = '0;
        else                     ps_n = ps_cnt + 8'd1;
    end

    // PRE and prescale counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre    <= '0;
            ps_cnt <= '0;
        end else begin
            if (wr_pre) pre <= bus.memWriteData[7:0];
            ps_cnt <= ps_n;
        end
    end
`else
    assign tick = ctrl[0];
`endif

    // Timer next state. Order matters: STAT clear is applied before the match
    // so a same-cycle match keeps PEND; CTRL write is applied after the
    // one-shot EN auto-clear so the CPU value wins.
    always_comb begin
        cnt_n  = cnt;
        ctrl_n = ctrl;
        pend_n = pend;
        if (wr_stat && bus.memWriteData[0]) pend_n = 1'b0;
        if (wr_cnt) begin
            cnt_n = bus.memWriteData;
        end else if (tick && (cnt == cmp)) begin
            pend_n = 1'b1;
            if (ctrl[2]) cnt_n     = '0;
            else         ctrl_n[0] = 1'b0;
        end else if (tick) begin
            cnt_n = cnt + 32'd1;
        end
        if (wr_ctrl) ctrl_n = bus.memWriteData[2:0];
    end

    // Timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            cmp  <= '0;
            ctrl <= '0;
            pend <= 1'b0;
        end else begin
            cnt  <= cnt_n;
            ctrl <= ctrl_n;
            pend <= pend_n;
            if (wr_cmp) cmp <= bus.memWriteData;
        end
    end

    // Load data mux: zero when not reading, I/O register or RAM word otherwise.
    logic [31:0] rdata;
    always_comb begin
        rdata = '0;
        if (bus.MemRead) begin
            if (io_sel) begin
                case (off)
                    OFF_CNT:  rdata = cnt;
                    OFF_CMP:  rdata = cmp;
                    OFF_CTRL: rdata = {29'd0, ctrl};
                    OFF_STAT: rdata = {31'd0, pend};
`ifdef BETA_DMEM_PRESCALE_EN
                    OFF_PRE:  rdata = {24'd0, pre};
`endif
                    default:  rdata = '0;
                endcase
            end else begin
                rdata = ram[idx];
            end
        end
    end

    assign bus.memReadData = rdata;
    assign bus.irq         = pend & ctrl[1];
endmodule

// File: tb/tb_beta_dmem_io.sv
// Directed self-checking bench for beta_dmem_io: RAM access, one-shot and
// auto-reload timer, wrap, CNT write priority, async reset, prescaler.
module tb_beta_dmem_io;
    localparam logic [31:0] A_CNT  = 32'hFFFF_0000;
    localparam logic [31:0] A_CMP  = 32'hFFFF_0004;
    localparam logic [31:0] A_CTRL = 32'hFFFF_0008;
    localparam logic [31:0] A_STAT = 32'hFFFF_000C;
    localparam logic [31:0] A_PRE  = 32'hFFFF_0010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    beta_dmem_if bus();

    beta_dmem_io dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #10 clk = ~clk;

    // Store: drive request, let one rising edge commit it, then idle the bus.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.memAddr = a; bus.memWriteData = d; bus.MemWrite = 1'b1; bus.MemRead = 1'b0;
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
    endtask

    // Combinational load without consuming a clock edge.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.memAddr = a; bus.MemRead = 1'b1;
        #1 d = bus.memReadData;
        bus.MemRead = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic timer_idle();
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        wr(A_CNT, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        bus.memAddr = 32'h0; bus.memWriteData = 32'h0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        reset = 1'b1;
        step(); step();
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
        reset = 1'b0;
        step();
        total++; if (bus.memReadData !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.memReadData); end
        peek(A_CNT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", v); end
        peek(A_CMP, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_cmp got=%h exp=0", v); end
        peek(A_CTRL, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", v); end
        peek(A_STAT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_stat got=%h exp=0", v); end
    endtask

    task automatic test_ram();
        logic [31:0] v;
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        peek(32'h0000_0010, v);
        total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd got=%h exp=deadbeef", v); end
        // index bits are [11:2]; bit 12 aliases onto the same word
        peek(32'h0000_1010, v);
        total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_alias got=%h exp=deadbeef", v); end
        bus.memAddr = 32'h0000_0010; bus.MemRead = 1'b0;
        #1;
        total++; if (bus.memReadData !== 32'h0) begin bad++; $display("FAIL ram_noread got=%h exp=0", bus.memReadData); end
        // same-cycle read and write: old data now, new data after the edge
        bus.MemRead = 1'b1; bus.MemWrite = 1'b1; bus.memWriteData = 32'hCAFE_F00D;
        #1;
        total++; if (bus.memReadData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rbw_old got=%h exp=deadbeef", bus.memReadData); end
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
        #1;
        total++; if (bus.memReadData !== 32'hCAFE_F00D) begin bad++; $display("FAIL ram_rbw_new got=%h exp=cafef00d", bus.memReadData); end
        bus.MemRead = 1'b0;
        peek(32'hFFFF_0020, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL io_unmapped got=%h exp=0", v); end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h3);
        for (int k = 0; k <= 5; k++) begin
            peek(A_CNT, v);
            total++; if (v !== k) begin bad++; $display("FAIL oneshot_cnt%0d got=%h exp=%h", k, v, k); end
            total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_early%0d got=%b exp=0", k, bus.irq); end
            step();
        end
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq got=%b exp=1", bus.irq); end
        peek(A_STAT, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL oneshot_pend got=%h exp=1", v); end
        peek(A_CTRL, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=2", v); end
        step(); step();
        peek(A_CNT, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL oneshot_hold got=%h exp=5", v); end
        timer_idle();
    endtask

    task automatic test_reload();
        logic [31:0] v;
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h7);
        for (int k = 0; k <= 3; k++) begin
            peek(A_CNT, v);
            total++; if (v !== k || bus.irq !== 1'b0) begin bad++; $display("FAIL reload_run%0d got=%h/%b exp=%h/0", k, v, bus.irq, k); end
            step();
        end
        peek(A_CNT, v);
        total++; if (bus.irq !== 1'b1 || v !== 32'h0) begin bad++; $display("FAIL reload_first got=%b/%h exp=1/0", bus.irq, v); end
        // clear in a non-match cycle (cnt=0)
        wr(A_STAT, 32'h1);
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reload_clear got=%b exp=0", bus.irq); end
        step(); step();
        peek(A_CNT, v);
        total++; if (v !== 32'd3) begin bad++; $display("FAIL reload_pre_match got=%h exp=3", v); end
        // clear in the match cycle: set wins
        wr(A_STAT, 32'h1);
        peek(A_CNT, v);
        total++; if (bus.irq !== 1'b1 || v !== 32'h0) begin bad++; $display("FAIL reload_race got=%b/%h exp=1/0", bus.irq, v); end
        // writing 0 to STAT leaves PEND alone
        wr(A_STAT, 32'h0);
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL stat_w0 got=%b exp=1", bus.irq); end
        timer_idle();
    endtask

    task automatic test_wrap_and_load();
        logic [31:0] v;
        logic [31:0] exp_seq [5];
        exp_seq[0] = 32'hFFFF_FFFE; exp_seq[1] = 32'hFFFF_FFFF;
        exp_seq[2] = 32'h0; exp_seq[3] = 32'h1; exp_seq[4] = 32'h2;
        wr(A_CMP, 32'd2);
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h3);
        for (int k = 0; k < 5; k++) begin
            peek(A_CNT, v);
            total++; if (v !== exp_seq[k] || bus.irq !== 1'b0) begin bad++; $display("FAIL wrap_cnt%0d got=%h/%b exp=%h/0", k, v, bus.irq, exp_seq[k]); end
            step();
        end
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL wrap_pend got=%b exp=1", bus.irq); end
        timer_idle();
        wr(A_CMP, 32'd100);
        wr(A_CTRL, 32'h1);
        step(); step();
        peek(A_CNT, v);
        total++; if (v !== 32'd2) begin bad++; $display("FAIL load_pre got=%h exp=2", v); end
        wr(A_CNT, 32'h50);
        peek(A_CNT, v);
        total++; if (v !== 32'h50) begin bad++; $display("FAIL load_noinc got=%h exp=50", v); end
        step();
        peek(A_CNT, v);
        total++; if (v !== 32'h51) begin bad++; $display("FAIL load_resume got=%h exp=51", v); end
        timer_idle();
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        wr(32'h0000_0040, 32'h1234_5678);
        wr(A_CMP, 32'h0);
        wr(A_CTRL, 32'h3);
        step();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL arst_setup got=%b exp=1", bus.irq); end
        #3 reset = 1'b1;
        #1;
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b exp=0", bus.irq); end
        peek(A_CTRL, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL arst_ctrl got=%h exp=0", v); end
        peek(A_STAT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL arst_stat got=%h exp=0", v); end
        peek(A_CNT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL arst_cnt got=%h exp=0", v); end
        @(negedge clk);
        reset = 1'b0;
        step();
        peek(32'h0000_0040, v);
        total++; if (v !== 32'h1234_5678) begin bad++; $display("FAIL arst_ram got=%h exp=12345678", v); end
        peek(32'h0000_0010, v);
        total++; if (v !== 32'hCAFE_F00D) begin bad++; $display("FAIL arst_ram2 got=%h exp=cafef00d", v); end
    endtask

`ifdef BETA_DMEM_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] v;
        wr(A_PRE, 32'h2);
        peek(A_PRE, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL pre_rd got=%h exp=2", v); end
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h3);
        // cnt advances on edges 3, 6; match on edge 9 after enable
        step(); step();
        peek(A_CNT, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL pre_cnt0 got=%h exp=0", v); end
        step();
        peek(A_CNT, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL pre_cnt1 got=%h exp=1", v); end
        step(); step(); step();
        peek(A_CNT, v);
        total++; if (v !== 32'd2) begin bad++; $display("FAIL pre_cnt2 got=%h exp=2", v); end
        step(); step();
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL pre_early got=%b exp=0", bus.irq); end
        step();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL pre_pend got=%b exp=1", bus.irq); end
        timer_idle();
        wr(A_PRE, 32'h0);
    endtask
`else
    task automatic test_prescale();
        logic [31:0] v;
        wr(A_PRE, 32'hFF);
        peek(A_PRE, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL pre_absent got=%h exp=0", v); end
    endtask
`endif

    initial begin
        test_reset();
        test_ram();
        test_oneshot();
        test_reload();
        test_wrap_and_load();
        test_prescale();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/beta_dmem_io.md
Name: beta_dmem_io

Overview:
- Data-memory responder for the beta core: services the core's memAddr / memWriteData / MemRead / MemWrite requests and returns memReadData.
- Contains a word RAM plus a memory-mapped interval timer.
- The timer drives the core's irq input.
- Single clock domain. Reads are combinational so the single-cycle core completes loads in one cycle. Writes commit on the rising clock edge.

Parameters:
- ADDR_W, 10, RAM word-index width; RAM holds 2**ADDR_W 32-bit words.
- IO_PAGE, 16'hFFFF, value of memAddr[31:16] that selects the I/O region.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- memAddr  in  32  byte address from the core
- memWriteData  in  32  store data
- MemRead  in  1  load strobe
- MemWrite  in  1  store strobe
- memReadData  out  32  load data, combinational
- irq  out  1  interrupt request to the core

Behaviour:
- Decode:
  - memAddr[31:16]==IO_PAGE selects I/O; otherwise RAM.
  - memAddr[1:0] ignored (word access only).
  - RAM index = memAddr[ADDR_W+1:2]. Upper bits are aliased, no fault.
- RAM:
  - Write on posedge clk when MemWrite=1.
  - Read = current contents at the index (read-before-write when MemRead and MemWrite are both high in one cycle).
  - Not cleared by reset.
- memReadData = 0 whenever MemRead=0.
- I/O registers, selected by offset memAddr[15:0]:
  - 0x0000 CNT (RW, 32b): timer count.
  - 0x0004 CMP (RW, 32b): compare value.
  - 0x0008 CTRL (RW, bits[2:0]; other bits read 0): bit0 EN, bit1 IE, bit2 RELOAD.
  - 0x000C STAT (bit0 PEND): reads PEND; writing 1 to bit0 clears PEND, writing 0 has no effect.
  - Any other offset reads 0; writes ignored.
- Reset values: CNT=0, CMP=0, CTRL=0, PEND=0, irq=0, memReadData=0 (MemRead is 0 from the core in reset).
- Timer per cycle, in priority order:
  1. A CPU write to CNT loads memWriteData. No increment that cycle.
  2. Otherwise, if EN=1 and CNT==CMP: set PEND.
     - RELOAD=1: CNT becomes 0 next cycle and EN stays 1.
     - RELOAD=0: CNT holds and EN clears.
  3. Otherwise, if EN=1: CNT increments by 1, wrapping 32'hFFFFFFFF to 0.
- Match is evaluated on the registered CNT, so PEND rises one cycle after CNT reaches CMP.
- CMP==0 with EN=1 matches on the first enabled cycle.
- Simultaneous PEND set (match) and STAT write-1-clear in the same cycle: set wins, so PEND=1.
- A CPU write to CTRL in the same cycle as a RELOAD=0 auto-clear of EN: the CPU write wins.
- irq = PEND & IE. It is a registered-state function, combinational from flops only, and stays level until cleared.
- Reset asserted mid-count: all timer state returns to reset values immediately. RAM is retained.

Optional Feature:
- Macro BETA_DMEM_PRESCALE_EN.
- Defined:
  - Adds register PRE at offset 0x0010 (RW, bits[7:0], reset 0) and an internal 8-bit prescale counter (reset 0).
  - While EN=1, the prescale counter counts 0..PRE. Step 2/3 timer actions happen only on the cycle the prescale counter equals PRE; the counter then returns to 0.
  - The prescale counter clears whenever EN=0 or CNT is written.
  - PRE=0 behaves identically to the macro being undefined.
- Undefined: offset 0x0010 reads 0 and writes are ignored. The timer acts every enabled cycle.

Test Plan:
- RAM write/read:
  - Write 0xDEADBEEF to 0x00000010, then read the same address → memReadData=0xDEADBEEF.
  - Read with MemRead=0 → 0.
  - Write and read the same address in one cycle → old value that cycle, new value the next.
- One-shot timer:
  - Set CMP=5, CTRL=0x3 → CNT counts 0..5.
  - PEND=1 and irq=1 exactly one cycle after CNT==5.
  - CNT then holds at 5 and CTRL reads 0x2.
- Auto-reload with clear race:
  - Set CMP=3, CTRL=0x7 → irq every 4 cycles.
  - Writing STAT=1 in a match cycle leaves PEND=1.
  - Writing STAT=1 in a non-match cycle drops irq on the next cycle.
- Wrap and CNT write priority:
  - Write CNT=0xFFFFFFFE with EN=1 and CMP=2 → CNT runs 0xFFFFFFFF, 0, 1, 2, then PEND sets.
  - A CNT write during counting suppresses that cycle's increment.
- Async reset mid-operation:
  - Assert reset between clock edges while irq=1 → irq and all registers read 0 immediately.
  - A RAM word written before the reset still reads back intact.
- Prescale (macro defined):
  - PRE=2, CMP=2, CTRL=0x3 → CNT advances every 3 cycles; PEND sets at the 3rd timer tick, about cycle 9.
  - Macro undefined: reading offset 0x10 returns 0.
